// File: rtl/zoh_pkg.sv
// Shared types and defaults for the zero-order-hold upsampler.
// Build option: ZOH_MUTE_ON_UNDERRUN_EN selects mute (held=0) instead of hold on underrun.
package zoh_pkg;

  localparam int unsigned DataWidthDefault = 20;

  typedef enum logic [1:0] {
    StWaitTick = 2'd0,
    StLoad     = 2'd1,
    StIssue    = 2'd2,
    StBusy     = 2'd3
  } zoh_state_e;

  // Counter/pointer width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/zoh_sample_fifo.sv
// Synchronous sample FIFO with registered, first-word fall-through output.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module zoh_sample_fifo
  import zoh_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DataWidthDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q, rd_next;
  logic [AW:0]      cnt_q;
  logic [WIDTH-1:0] dout_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_next = rd_ptr_q + 1'b1;
  assign dout    = dout_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_next;
      end
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      // Head register follows the oldest entry; bypass din when it becomes the head.
      if (do_push && (empty || (do_pop && cnt_q == (AW+1)'(1)))) begin
        dout_q <= din;
      end else if (do_pop) begin
        dout_q <= mem_q[rd_next];
      end
    end
  end

endmodule

// File: rtl/zoh_upsampler.sv
// Zero-order-hold upsampler and output pacer feeding the PCM1702 serial interface.
// Build option: ZOH_MUTE_ON_UNDERRUN_EN mutes (held=0) on underrun; default holds last sample.
module zoh_upsampler
  import zoh_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDefault,
  parameter int unsigned UPSAMPLE   = 4,
  parameter int unsigned OUT_PERIOD = 512,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  shift_done,
  output logic                  sample_rdy,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  err_clr,
  output logic                  underrun,
  output logic                  overrun
);

  localparam int unsigned TW = clog2_min1(OUT_PERIOD);
  localparam int unsigned RW = clog2_min1(UPSAMPLE);

  zoh_state_e            state_q, state_d;
  logic [TW-1:0]         tick_cnt_q;
  logic                  tick;
  logic [RW-1:0]         rep_q, rep_d;
  logic [DATA_WIDTH-1:0] held_q, held_d, data_q;
  logic                  underrun_q, overrun_q;
  logic                  ur_set, ov_set;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;

  zoh_sample_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (in_valid),
    .pop  (fifo_pop),
    .din  (in_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign tick     = (tick_cnt_q == TW'(OUT_PERIOD - 1));
  assign data     = data_q;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;

  always_comb begin
    state_d    = state_q;
    rep_d      = rep_q;
    held_d     = held_q;
    fifo_pop   = 1'b0;
    ur_set     = 1'b0;
    ov_set     = 1'b0;
    sample_rdy = 1'b0;
    unique case (state_q)
      StWaitTick: begin
        if (tick) state_d = StLoad;
      end
      StLoad: begin
        if (rep_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            held_d   = fifo_dout;
            rep_d    = RW'(UPSAMPLE - 1);
          end else begin
            ur_set = 1'b1;
`ifdef ZOH_MUTE_ON_UNDERRUN_EN
            held_d = '0;
`else
            held_d = held_q;
`endif
          end
        end else begin
          rep_d = rep_q - 1'b1;
        end
        state_d = StIssue;
      end
      StIssue: begin
        sample_rdy = 1'b1;
        state_d    = StBusy;
      end
      StBusy: begin
        // A tick here is lost, not queued; the following tick is served normally.
        if (tick) ov_set = 1'b1;
        if (shift_done) state_d = StWaitTick;
      end
      default: state_d = StWaitTick;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StWaitTick;
      tick_cnt_q <= '0;
      rep_q      <= '0;
      held_q     <= '0;
      data_q     <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      rep_q      <= rep_d;
      held_q     <= held_d;
      // Output word is updated on the edge entering ISSUE so it is valid alongside sample_rdy.
      if (state_q == StLoad) begin
        data_q <= held_d;
      end
      underrun_q <= ur_set | (underrun_q & ~err_clr);
      overrun_q  <= ov_set | (overrun_q & ~err_clr);
    end
  end

endmodule

// File: tb/tb_zoh_upsampler.sv
// Directed, table-driven bench for zoh_upsampler with a small OUT_PERIOD to keep runs short.
module tb_zoh_upsampler;

  localparam int unsigned DW = 20;
  localparam int unsigned UP = 4;
  localparam int unsigned P  = 32;
  localparam int unsigned FD = 4;

`ifdef ZOH_MUTE_ON_UNDERRUN_EN
  localparam logic [DW-1:0] UR_DATA = 20'h00000;
`else
  localparam logic [DW-1:0] UR_DATA = 20'h80000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          shift_done;
  logic          resp_sd = 1'b0;
  logic          man_sd = 1'b0;
  logic          sample_rdy;
  logic [DW-1:0] data;
  logic          err_clr = 1'b0;
  logic          underrun;
  logic          overrun;

  assign shift_done = resp_sd | man_sd;

  zoh_upsampler #(
    .DATA_WIDTH(DW),
    .UPSAMPLE  (UP),
    .OUT_PERIOD(P),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .shift_done(shift_done),
    .sample_rdy(sample_rdy),
    .data      (data),
    .err_clr   (err_clr),
    .underrun  (underrun),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit auto_ack = 1'b0;

  // DAC model: acknowledge each sample_rdy ten cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (sample_rdy && auto_ack) begin
        repeat (10) @(posedge clk);
        #1 resp_sd = 1'b1;
        @(posedge clk);
        #1 resp_sd = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  int last_rdy_cyc = 0;

  task automatic wait_rdy(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (sample_rdy) begin
        ok = 1'b1;
        last_rdy_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic manual_ack();
    man_sd = 1'b1;
    @(posedge clk);
    #1 man_sd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    bit            push;
    logic [DW-1:0] pdata;
    logic [DW-1:0] exp_data;
    bit            exp_ur;
  } vec_t;

  vec_t vecs[14];

  initial begin
    bit ok;
    int prev;
    int extra;
    bit stable;
    logic [DW-1:0] words[6];
    logic [DW-1:0] seq[5];

    for (int i = 0; i < 14; i++) vecs[i] = '{1'b0, '0, '0, 1'b0};
    vecs[0]  = '{1'b1, 20'h12345, 20'h12345, 1'b0};
    vecs[1]  = '{1'b0, 20'h0,     20'h12345, 1'b0};
    vecs[2]  = '{1'b0, 20'h0,     20'h12345, 1'b0};
    vecs[3]  = '{1'b1, 20'h7FFFF, 20'h12345, 1'b0};
    vecs[4]  = '{1'b1, 20'h80000, 20'h7FFFF, 1'b0};
    for (int i = 5; i < 8; i++)  vecs[i] = '{1'b0, 20'h0, 20'h7FFFF, 1'b0};
    for (int i = 8; i < 12; i++) vecs[i] = '{1'b0, 20'h0, 20'h80000, 1'b0};
    vecs[12] = '{1'b0, 20'h0, UR_DATA, 1'b1};
    vecs[13] = '{1'b0, 20'h0, UR_DATA, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample_rdy", sample_rdy, 0);
    chk("rst_data", data, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    auto_ack = 1'b1;

    // Repetition, back-to-back samples, then drain into underrun
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].push) push_word(vecs[i].pdata);
      prev = last_rdy_cyc;
      wait_rdy(2 * P + 4, ok);
      chk($sformatf("vec%0d_rdy", i), ok, 1);
      chk($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      chk($sformatf("vec%0d_underrun", i), underrun, vecs[i].exp_ur);
      chk($sformatf("vec%0d_overrun", i), overrun, 0);
      if (i > 0) chk($sformatf("vec%0d_spacing", i), last_rdy_cyc - prev, P);
    end

    // err_clr alone clears; err_clr coinciding with a set lets the set win
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    chk("errclr_underrun", underrun, 0);
    err_clr = 1'b1;
    wait_rdy(2 * P + 4, ok);
    chk("setwins_rdy", ok, 1);
    chk("setwins_underrun", underrun, 1);
    @(posedge clk);
    #1;
    chk("clr_after_set_underrun", underrun, 0);
    err_clr = 1'b0;

    // Overrun: withhold shift_done for 1.5 output periods
    push_word(20'h00ABC);
    auto_ack = 1'b0;
    wait_rdy(2 * P + 4, ok);
    chk("ovr_rdy", ok, 1);
    chk("ovr_data", data, 20'h00ABC);
    chk("ovr_pre_overrun", overrun, 0);
    prev = last_rdy_cyc;
    extra = 0;
    stable = 1'b1;
    for (int i = 0; i < (3 * P) / 2; i++) begin
      @(posedge clk);
      #1;
      if (sample_rdy) extra++;
      if (data !== 20'h00ABC) stable = 1'b0;
    end
    chk("ovr_busy_stable", stable, 1);
    chk("ovr_no_rdy_in_busy", extra, 0);
    chk("ovr_overrun", overrun, 1);
    manual_ack();
    wait_rdy(2 * P + 4, ok);
    chk("ovr_next_rdy", ok, 1);
    chk("ovr_skip_spacing", last_rdy_cyc - prev, 2 * P);
    chk("ovr_next_data", data, 20'h00ABC);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    manual_ack();

    // FIFO full: words 5-6 dropped, push+pop at full accepted
    do_reset();
    auto_ack = 1'b1;
    words[0] = 20'h00001; words[1] = 20'h00002; words[2] = 20'h00003;
    words[3] = 20'h00004; words[4] = 20'h00005; words[5] = 20'h00006;
    for (int i = 0; i < 6; i++) begin
      push_word(words[i]);
      chk($sformatf("fill%0d_in_ready", i), in_ready, (i + 1 < FD) ? 1 : 0);
    end
    in_valid = 1'b1;
    in_data  = 20'h00777;
    wait_rdy(2 * P + 4, ok);
    in_valid = 1'b0;
    chk("full_pp_rdy", ok, 1);
    chk("full_pp_in_ready", in_ready, 0);
    seq[0] = 20'h00001; seq[1] = 20'h00002; seq[2] = 20'h00003;
    seq[3] = 20'h00004; seq[4] = 20'h00777;
    chk("full_seq0", data, seq[0]);
    for (int j = 1; j < 20; j++) begin
      wait_rdy(2 * P + 4, ok);
      chk($sformatf("full_seq%0d_rdy", j), ok, 1);
      chk($sformatf("full_seq%0d", j), data, seq[j / 4]);
    end
    auto_ack = 1'b0;
    chk("full_no_underrun", underrun, 0);

    // Reset mid-shift, then a late shift_done
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_sample_rdy", sample_rdy, 0);
    chk("midrst_data", data, 0);
    chk("midrst_underrun", underrun, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    manual_ack();
    extra = 0;
    for (int i = 0; i < P - 8; i++) begin
      @(posedge clk);
      #1;
      if (sample_rdy) extra++;
    end
    chk("postrst_no_rdy", extra, 0);
    push_word(20'h55555);
    wait_rdy(2 * P + 4, ok);
    chk("postrst_rdy", ok, 1);
    chk("postrst_data", data, 20'h55555);
    chk("postrst_underrun", underrun, 0);
    manual_ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
